circuit1_input_debounce: RTL
============================

// Module: circuit1_input_debounce
// PURPOSE
//   Input conditioning stage directly upstream of the circuit1 logic. Takes raw,
//   asynchronous switch/pin levels for a, b, c and produces synchronized,
//   debounced levels that feed circuit1's a, b, c inputs.
//   Also emits a one-cycle "changed" strobe whenever any conditioned bit updates.
//   Each channel has:
//     - a 2-flop synchronizer, then
//     - a stability counter FSM.
// PARAMETERS
//   WIDTH          3  number of independent input channels (bit0=a, bit1=b, bit2=c)
//   STABLE_CYCLES  4  consecutive mismatching samples required before accepting a new level; legal 2..2**CNT_W
//   CNT_W          2  stability counter width; must satisfy 2**CNT_W >= STABLE_CYCLES
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      synchronous, active-low reset (sampled on rising clk edge)
//   raw_in     in   WIDTH  asynchronous raw levels {c,b,a}
//   clean_out  out  WIDTH  debounced levels {c,b,a} to circuit1
//   changed    out  1      1-cycle pulse, high in the cycle clean_out takes a new value
//   busy       out  1      OR of all channels in PENDING (a transition is being qualified)
// BEHAVIOUR
//   Reset (rst_n=0 at an edge):
//     - sync flops, clean_out, counters, changed and busy all go to 0;
//     - every channel FSM goes to STABLE.
//     - Reset asserted mid-qualification discards the pending count.
//     - raw_in is ignored until rst_n=1.
//   Synchronizer: s1<=raw_in; s2<=s1. s2 is the only value the FSM sees.
//   Per-channel FSM, evaluated on s2[i] vs clean_out[i]:
//     STABLE:
//       - s2==clean: stay, cnt=0.
//       - s2!=clean: go PENDING, cnt<=1.
//     PENDING:
//       - s2==clean: glitch; go STABLE, cnt<=0, clean unchanged.
//       - s2!=clean and cnt<STABLE_CYCLES-1: cnt<=cnt+1.
//       - s2!=clean and cnt==STABLE_CYCLES-1: clean<=s2, cnt<=0, go STABLE, changed_i<=1.
//   Latency:
//     - A clean raw step sampled at edge E appears on clean_out after edge E+1+STABLE_CYCLES,
//       i.e. 2 sync edges plus STABLE_CYCLES qualifying samples (edge E+5 for default 4).
//     - Pulses shorter than STABLE_CYCLES samples (after sync) never reach clean_out.
//   changed:
//     - Registered OR of per-channel changed_i; high exactly one cycle per update event.
//     - Simultaneous updates on several channels in the same cycle give a single 1-cycle pulse.
//     - Back-to-back updates on different channels in consecutive cycles give changed high
//       for both cycles; no merging is required.
//   busy: combinational OR of (state==PENDING) across channels; 0 in reset.
//   Counter never wraps: the max value reached is STABLE_CYCLES-1, then it clears.
//   No combinational path from raw_in to any output.
// STRUCTURE
//   circuit1_pkg:
//     - typedef enum logic {ST_STABLE, ST_PENDING} deb_state_t;
//     - default constants DEB_WIDTH=3, DEB_STABLE_CYCLES=4, DEB_CNT_W=2.
//   Sub-module debounce_channel (one bit):
//     - contains the synchronizer, counter and FSM;
//     - ports clk, rst_n, raw, clean, upd, pending.
//   Top instantiates WIDTH copies via generate, ORs upd into the changed register,
//   and ORs pending into busy.
//   Top-level output clean_out connects 1:1 to circuit1 a/b/c in the integration wrapper.
// TESTING
//   1. Reset: raw_in=3'b111 held, rst_n=0 for 3 edges -> clean_out=000, changed=0, busy=0 throughout.
//   2. Clean step: after reset raw_in 000->001 at edge E -> busy=1 from edge E+2;
//      clean_out=001 and changed=1 after edge E+5; changed=0 after E+6.
//   3. Glitch reject: raw_in[1] high for exactly 3 cycles then low -> clean_out stays 000,
//      changed never asserts, busy returns 0.
//   4. Simultaneous: raw_in 000->101 in one cycle -> clean_out 000->101 in one cycle,
//      changed high for exactly one cycle.
//   5. Reset mid-qualification: raw_in=010, rst_n=0 at edge E+4 (count=2) then released
//      -> clean_out=000; full 2+4 edges are needed again before clean_out=010.
//   6. Bounce: raw_in[2] toggles every 2 cycles for 20 cycles, then holds 1
//      -> clean_out[2] stays 0 during the toggling and rises 6 edges after the hold begins.

Source files
------------

// File: rtl/circuit1_input_debounce_pkg.sv
// Shared types and default sizing for the circuit1 input conditioning stage.
package circuit1_pkg;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } deb_state_t;

   localparam int DEB_WIDTH         = 3;
   localparam int DEB_STABLE_CYCLES = 4;
   localparam int DEB_CNT_W         = 2;

endpackage : circuit1_pkg

// File: rtl/circuit1_input_debounce_if.sv
// Raw-level input and conditioned-level output bundle of the debounce stage.
interface circuit1_input_debounce_if
   import circuit1_pkg::*;
#(
   parameter int WIDTH = DEB_WIDTH
);

   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clean_out;
   logic             changed;
   logic             busy;

   modport master (
      output raw_in,
      input  clean_out,
      input  changed,
      input  busy
   );

   modport slave (
      input  raw_in,
      output clean_out,
      output changed,
      output busy
   );

endinterface : circuit1_input_debounce_if

// File: rtl/circuit1_input_debounce_channel.sv
// One debounce channel: 2-flop synchronizer feeding a stability-counter FSM.
module debounce_channel
   import circuit1_pkg::*;
#(
   parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int CNT_W         = DEB_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic clean,
   output logic upd,
   output logic pending
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_clean;
   deb_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;

   deb_state_t       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_clean_nxt;
   logic             w_upd;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_clean <= 1'b0;
         r_state <= ST_STABLE;
         r_cnt   <= '0;
      end else begin
         r_s1    <= raw;
         r_s2    <= r_s1;
         r_clean <= w_clean_nxt;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clean_nxt = r_clean;
      w_upd       = 1'b0;
      unique case (r_state)
         ST_STABLE: begin
            if (r_s2 != r_clean) begin
               w_state_nxt = ST_PENDING;
               w_cnt_nxt   = CNT_W'(1);
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         ST_PENDING: begin
            if (r_s2 == r_clean) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               // Final qualifying sample: accept the new level and clear for the next event.
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
               w_clean_nxt = r_s2;
               w_upd       = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   assign clean   = r_clean;
   assign upd     = w_upd;
   assign pending = (r_state == ST_PENDING);

endmodule : debounce_channel

// File: rtl/circuit1_input_debounce.sv
// Debounce front end for circuit1 a/b/c: per-bit channels plus shared changed/busy flags.
module circuit1_input_debounce
   import circuit1_pkg::*;
#(
   parameter int WIDTH         = DEB_WIDTH,
   parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int CNT_W         = DEB_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   circuit1_input_debounce_if.slave   bus
);

   logic [WIDTH-1:0] w_clean;
   logic [WIDTH-1:0] w_upd;
   logic [WIDTH-1:0] w_pending;
   logic             r_changed;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
         debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
         ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (bus.raw_in[gi]),
            .clean   (w_clean[gi]),
            .upd     (w_upd[gi]),
            .pending (w_pending[gi])
         );
      end
   endgenerate

   // Registered alongside clean, so the pulse lines up with the cycle the new level appears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_upd;
      end
   end

   assign bus.clean_out = w_clean;
   assign bus.changed   = r_changed;
   assign bus.busy      = |w_pending;

endmodule : circuit1_input_debounce
